// File: rtl/audio_envelope.sv
// Attack/sustain/release gain envelope applied to a stereo tone stream.
// Define ENVELOPE_RELEASE_EN to ramp down on rests; otherwise a rest cuts straight to IDLE.
module audio_envelope #(
    parameter int STEP_CYCLES = 100000,
    parameter int GAIN_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [22:0]         note_div,
    input  logic [15:0]         audio_in_left,
    input  logic [15:0]         audio_in_right,
    input  logic [3:0]          volume,
    input  logic                mute,
    output logic [15:0]         audio_out_left,
    output logic [15:0]         audio_out_right,
    output logic [1:0]          env_state,
    output logic [GAIN_W-1:0]   gain
);
    // state   | meaning
    // IDLE    | silent, g = 0, waiting for a note
    // ATTACK  | g climbs one step per tick toward volume
    // SUSTAIN | g follows volume
    // RELEASE | g falls one step per tick to 0 (release builds only)

    localparam int CNT_W  = $clog2(STEP_CYCLES);
    localparam int PROD_W = 17 + GAIN_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    env_state_t         state, state_nxt;
    logic [GAIN_W-1:0]  g, g_nxt, g_inc, vol_g;
    logic [22:0]        note_q;
    logic [CNT_W-1:0]   cnt;
    logic               note_event, tick;

    logic signed [PROD_W-1:0] in_l_ext, in_r_ext, gain_ext, prod_l, prod_r;

    assign note_event = (note_div != note_q);
    assign tick       = (cnt == CNT_LAST);
    assign vol_g      = GAIN_W'(volume);
    assign g_inc      = g + GAIN_W'(1);

    // A note event outranks a coincident tick: g holds for that cycle.
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        if (note_event) begin
            if (note_div != '0) begin
                state_nxt = ST_ATTACK;
            end else if (state == ST_ATTACK || state == ST_SUSTAIN) begin
`ifdef ENVELOPE_RELEASE_EN
                state_nxt = ST_RELEASE;
`else
                state_nxt = ST_IDLE;
                g_nxt     = '0;
`endif
            end
        end else if (tick) begin
            case (state)
                ST_IDLE: g_nxt = '0;
                ST_ATTACK: begin
                    if (g >= vol_g) begin
                        g_nxt     = vol_g;
                        state_nxt = ST_SUSTAIN;
                    end else begin
                        g_nxt = g_inc;
                        if (g_inc == vol_g) state_nxt = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: g_nxt = vol_g;
`ifdef ENVELOPE_RELEASE_EN
                ST_RELEASE: begin
                    if (g == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        g_nxt = g - GAIN_W'(1);
                        if (g == GAIN_W'(1)) state_nxt = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_nxt = ST_IDLE;
                    g_nxt     = '0;
                end
            endcase
        end
    end

    // Unsigned gain is zero-extended so the signed product stays exact.
    assign in_l_ext = {{(PROD_W-16){audio_in_left[15]}}, audio_in_left};
    assign in_r_ext = {{(PROD_W-16){audio_in_right[15]}}, audio_in_right};
    assign gain_ext = {{(PROD_W-GAIN_W){1'b0}}, g};
    assign prod_l   = in_l_ext * gain_ext;
    assign prod_r   = in_r_ext * gain_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            g               <= '0;
            note_q          <= '0;
            cnt             <= '0;
            audio_out_left  <= '0;
            audio_out_right <= '0;
        end else begin
            state  <= state_nxt;
            g      <= g_nxt;
            note_q <= note_div;
            if (note_event || tick) cnt <= '0;
            else                    cnt <= cnt + CNT_W'(1);
            if (mute) begin
                audio_out_left  <= '0;
                audio_out_right <= '0;
            end else begin
                audio_out_left  <= 16'(prod_l >>> 4);
                audio_out_right <= 16'(prod_r >>> 4);
            end
        end
    end

    assign env_state = state;
    assign gain      = g;

endmodule

// File: tb/tb_audio_envelope.sv
// Self-checking bench for audio_envelope: directed envelope sequences, a sample
// scaling table and a randomized run against a behavioural envelope model.
module tb_audio_envelope;
    localparam int STEP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] note_div;
    logic [15:0] audio_in_left, audio_in_right;
    logic [3:0]  volume;
    logic        mute;
    logic [15:0] audio_out_left, audio_out_right;
    logic [1:0]  env_state;
    logic [3:0]  gain;

    audio_envelope #(.STEP_CYCLES(STEP), .GAIN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .note_div(note_div),
        .audio_in_left(audio_in_left), .audio_in_right(audio_in_right),
        .volume(volume), .mute(mute),
        .audio_out_left(audio_out_left), .audio_out_right(audio_out_right),
        .env_state(env_state), .gain(gain)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural reference: 0 idle, 1 attack, 2 sustain, 3 release.
    int          m_state, m_g, m_phase;
    logic [22:0] m_note;
    logic [15:0] m_out_l, m_out_r;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] scale(input logic [15:0] s, input int gv);
        int p;
        p = int'($signed(s)) * gv;
        p = p >>> 4;
        return p[15:0];
    endfunction

    task automatic model_clock();
        bit ev, tk;
        if (!rst_n) begin
            m_state = 0; m_g = 0; m_note = '0; m_phase = 0;
            m_out_l = '0; m_out_r = '0;
            return;
        end
        m_out_l = mute ? 16'h0 : scale(audio_in_left, m_g);
        m_out_r = mute ? 16'h0 : scale(audio_in_right, m_g);
        ev = (note_div != m_note);
        tk = (m_phase == STEP - 1);
        m_note  = note_div;
        m_phase = ev ? 0 : (m_phase + 1) % STEP;
        if (ev) begin
            if (note_div != 0) m_state = 1;
            else if (m_state == 1 || m_state == 2) begin
`ifdef ENVELOPE_RELEASE_EN
                m_state = 3;
`else
                m_state = 0; m_g = 0;
`endif
            end
        end else if (tk) begin
            if (m_state == 1) begin
                m_g = (m_g < int'(volume)) ? m_g + 1 : int'(volume);
                if (m_g == int'(volume)) m_state = 2;
            end else if (m_state == 2) begin
                m_g = int'(volume);
            end else if (m_state == 3) begin
                m_g = (m_g > 0) ? m_g - 1 : 0;
                if (m_g == 0) m_state = 0;
            end
        end
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        check("model_state", int'(env_state), m_state);
        check("model_gain", int'(gain), m_g);
        check("model_out_l", int'(audio_out_left), int'(m_out_l));
        check("model_out_r", int'(audio_out_right), int'(m_out_r));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic [15:0] in_l;
        logic [15:0] in_r;
        logic        mute;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Scaling at g = 15 (gain 15/16), values worked by hand.
        vecs[0] = '{16'h7FFF, 16'h8000, 1'b0, 16'h77FF, 16'h8800};
        vecs[1] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF};
        vecs[2] = '{16'h0010, 16'hFFF0, 1'b0, 16'h000F, 16'hFFF1};
        vecs[3] = '{16'h1000, 16'hF000, 1'b0, 16'h0F00, 16'hF100};
        vecs[4] = '{16'h0100, 16'hFF00, 1'b0, 16'h00F0, 16'hFF10};
        vecs[5] = '{16'h7FFF, 16'h8000, 1'b1, 16'h0000, 16'h0000};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};

        rst_n = 1'b0; note_div = '0; volume = 4'd15; mute = 1'b0;
        audio_in_left = 16'h1234; audio_in_right = 16'h8765;
        steps(2);
        check("reset_state", int'(env_state), 0);
        check("reset_gain", int'(gain), 0);
        check("reset_out_l", int'(audio_out_left), 0);
        check("reset_out_r", int'(audio_out_right), 0);

        rst_n = 1'b1; audio_in_left = '0; audio_in_right = '0;
        step();
        note_div = 23'd191571;
        step();
        check("attack_entry_state", int'(env_state), 1);
        check("attack_entry_gain", int'(gain), 0);
        for (int k = 1; k <= 15; k++) begin
            steps(STEP);
            check("attack_ramp_gain", int'(gain), k);
            check("attack_ramp_state", int'(env_state), (k == 15) ? 2 : 1);
        end

        for (int i = 0; i < 7; i++) begin
            audio_in_left = vecs[i].in_l; audio_in_right = vecs[i].in_r; mute = vecs[i].mute;
            step();
            check("table_out_l", int'(audio_out_left), int'(vecs[i].exp_l));
            check("table_out_r", int'(audio_out_right), int'(vecs[i].exp_r));
        end
        mute = 1'b0;

        volume = 4'd5;
        steps(STEP);
        check("volume_track_gain", int'(gain), 5);
        check("volume_track_state", int'(env_state), 2);
        audio_in_left = 16'h4000; audio_in_right = 16'hC000; mute = 1'b1;
        step();
        check("mute_out_l", int'(audio_out_left), 0);
        check("mute_out_r", int'(audio_out_right), 0);
        check("mute_gain_kept", int'(gain), 5);
        mute = 1'b0; volume = 4'd15;
        steps(STEP);
        check("sustain_regain", int'(gain), 15);

        note_div = '0;
        step();
`ifdef ENVELOPE_RELEASE_EN
        check("release_entry_state", int'(env_state), 3);
        check("release_entry_gain", int'(gain), 15);
        for (int k = 1; k <= 15; k++) begin
            steps(STEP);
            check("release_ramp_gain", int'(gain), 15 - k);
            check("release_ramp_state", int'(env_state), (k == 15) ? 0 : 3);
        end
`else
        check("rest_cut_state", int'(env_state), 0);
        check("rest_cut_gain", int'(gain), 0);
`endif
        steps(3);

        note_div = 23'd191571;
        step();
        steps(7 * STEP);
        check("retrig_pre_gain", int'(gain), 7);
        steps(2);
        note_div = 23'd170648;
        step();
        check("retrig_state", int'(env_state), 1);
        check("retrig_gain_held", int'(gain), 7);
        steps(STEP - 1);
        check("retrig_prescaler_cleared", int'(gain), 7);
        step();
        check("retrig_next_tick", int'(gain), 8);

        audio_in_left = 16'h7FFF; audio_in_right = 16'h8000;
        steps(2);
        rst_n = 1'b0;
        step();
        check("midreset_state", int'(env_state), 0);
        check("midreset_gain", int'(gain), 0);
        check("midreset_out_l", int'(audio_out_left), 0);
        check("midreset_out_r", int'(audio_out_right), 0);
        rst_n = 1'b1;
        step();
        check("postreset_attack", int'(env_state), 1);

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: note_div = '0;
                    1: note_div = 23'd191571;
                    2: note_div = 23'd170648;
                    default: note_div = 23'($urandom);
                endcase
            end
            if ($urandom_range(0, 49) == 0) volume = 4'($urandom);
            if ($urandom_range(0, 29) == 0) mute = ~mute;
            rst_n = ($urandom_range(0, 499) != 0);
            audio_in_left  = 16'($urandom);
            audio_in_right = 16'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
